// File: rtl/sample_packer.sv
// sample_packer: packs bit slices of complex multi-channel samples into OW-bit words.
//
// Each accepted sample contributes, for every enabled channel in ascending order, a B-bit
// slice of I followed by a B-bit slice of Q (earliest bit at the MSB). The P-bit strings are
// concatenated MSB-first into OW-bit words and queued in a fall-through FIFO.
//
// Ports:
//   source_clk      clock, all state changes on the rising edge
//   source_reset_n  asynchronous active-low reset
//   in_i / in_q     NCH packed W-bit components (channel c at [c*W +: W])
//   in_valid        sample strobe, cannot be stalled
//   cfg_mask/bps/shift, cfg_load   configuration, latched on the cfg_load pulse
//   out_data/out_valid/out_ready   FIFO head and handshake
//   cfg_err         latched configuration is illegal
//   overflow_count  saturating count of words dropped on a full FIFO
module sample_packer #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned OW    = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic               source_clk,
    input  logic               source_reset_n,
    input  logic [NCH*W-1:0]   in_i,
    input  logic [NCH*W-1:0]   in_q,
    input  logic               in_valid,
    input  logic [NCH-1:0]     cfg_mask,
    input  logic [1:0]         cfg_bps,
    input  logic [2:0]         cfg_shift,
    input  logic               cfg_load,
    output logic [OW-1:0]      out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               cfg_err,
    output logic [15:0]        overflow_count
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned FW  = $clog2(2 * OW);
    // Widest compacted string any mask/bps could produce, never narrower than a word.
    localparam int unsigned PKW = (2 * NCH * 8 > OW) ? 2 * NCH * 8 : OW;

    // ---------------------------------------------------------------- configuration
    logic [NCH-1:0] mask_q;
    logic [1:0]     bps_q;
    logic [2:0]     shift_q;

    logic [3:0]     b_len;
    logic [3:0]     ch_cnt;
    logic [7:0]     p_len;

    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            mask_q  <= NCH'(1);
            bps_q   <= 2'd3;
            shift_q <= 3'd0;
        end else if (cfg_load) begin
            mask_q  <= cfg_mask;
            bps_q   <= cfg_bps;
            shift_q <= cfg_shift;
        end
    end

    always_comb begin
        b_len  = 4'd1 << bps_q;
        ch_cnt = 4'd0;
        for (int c = 0; c < int'(NCH); c++) begin
            ch_cnt = ch_cnt + 4'(mask_q[c]);
        end
        p_len   = ({4'b0, ch_cnt} * {4'b0, b_len}) << 1;
        cfg_err = (ch_cnt == 4'd0) ||
                  (int'(p_len) > int'(OW)) ||
                  (int'(shift_q) + int'(b_len) > int'(W));
    end

    // ---------------------------------------------------------------- stage 1: compaction
    function automatic logic [7:0] take_slice(input logic [W-1:0] comp, input int lsb,
                                              input logic [3:0] blen);
        logic [W+7:0] wide;
        logic [8:0]   msk;
        wide = {8'b0, comp} >> lsb;
        msk  = (9'd1 << blen) - 9'd1;
        return wide[7:0] & msk[7:0];
    endfunction

    logic [PKW-1:0] pk;
    int             lsb;
    logic           s1_valid_q, s1_valid_d;
    logic [OW-1:0]  s1_bits_q, s1_bits_d;

    always_comb begin
        pk  = '0;
        lsb = int'(W) - int'(b_len) - int'(shift_q);
        if (lsb < 0) begin
            lsb = 0;
        end
        // Right-aligned: the first appended slice ends up in the most significant position.
        for (int c = 0; c < int'(NCH); c++) begin
            if (mask_q[c]) begin
                pk = (pk << b_len) | PKW'(take_slice(in_i[c*W +: W], lsb, b_len));
                pk = (pk << b_len) | PKW'(take_slice(in_q[c*W +: W], lsb, b_len));
            end
        end
        s1_valid_d = in_valid && !cfg_err && !cfg_load;
        s1_bits_d  = pk[OW-1:0];
    end

    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            s1_valid_q <= 1'b0;
            s1_bits_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_bits_q  <= s1_bits_d;
        end
    end

    // ---------------------------------------------------------------- stage 2: accumulator
    // acc_q is left-aligned; bits below the fill point are always zero.
    logic [2*OW-1:0] acc_q, acc_d, acc_n, acc_ext;
    logic [FW-1:0]   fill_q, fill_d;
    logic            push;
    logic [OW-1:0]   push_word;
    int              sum;
    int              ins_sh;

    always_comb begin
        acc_d     = acc_q;
        fill_d    = fill_q;
        push      = 1'b0;
        push_word = acc_q[2*OW-1:OW];
        sum       = int'(fill_q) + int'(p_len);
        ins_sh    = 2 * int'(OW) - sum;
        if (ins_sh < 0) begin
            ins_sh = 0;
        end
        acc_ext   = {{OW{1'b0}}, s1_bits_q};
        acc_n     = acc_q | (acc_ext << ins_sh);
        if (cfg_load) begin
            // Partial word and the sample in stage 1 are both discarded.
            acc_d  = '0;
            fill_d = '0;
        end else if (s1_valid_q) begin
            if (sum >= int'(OW)) begin
                push      = 1'b1;
                push_word = acc_n[2*OW-1:OW];
                acc_d     = acc_n << OW;
                fill_d    = FW'(sum - int'(OW));
            end else begin
                acc_d  = acc_n;
                fill_d = FW'(sum);
            end
        end
    end

    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    // ---------------------------------------------------------------- output FIFO
    logic [OW-1:0] mem_q [DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic          empty, full, pop, wr_en, drop;
    logic [15:0]   ovf_q;

    always_comb begin
        empty = (wptr_q == rptr_q);
        full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop   = !empty && out_ready;
        // A pop frees the head slot in the same cycle, so a full FIFO still takes the push.
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
    end

    always_ff @(posedge source_clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= push_word;
        end
    end

    always_ff @(posedge source_clk or negedge source_reset_n) begin
        if (!source_reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= '0;
        end else begin
            if (wr_en) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (drop && ovf_q != 16'hFFFF) begin
                ovf_q <= ovf_q + 16'd1;
            end
        end
    end

    assign out_valid      = !empty;
    assign out_data       = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign overflow_count = ovf_q;

endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 Parameter NCH, default 4: number of complex sample channels, range 1..8.
REQ-002 Parameter W, default 8: bits per I or Q component.
REQ-003 Parameter OW, default 16: output word width, a multiple of 8.
REQ-004 Parameter DEPTH, default 8: output FIFO depth in words, power of two, at least 2.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 Port source_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 Port source_reset_n, input, 1: asynchronous active-low reset.
REQ-008 Port in_i, input, NCH*W: I components; channel c occupies bits [c*W+W-1 : c*W], binary offset.
REQ-009 Port in_q, input, NCH*W: Q components, same layout as in_i.
REQ-010 Port in_valid, input, 1: sample strobe; the input cannot be stalled.
REQ-011 Port cfg_mask, input, NCH: channel enable mask.
REQ-012 Port cfg_bps, input, 2: component bits B, where 0 gives 1, 1 gives 2, 2 gives 4, 3 gives 8.
REQ-013 Port cfg_shift, input, 3: MSB offset of the bit slice.
REQ-014 Port cfg_load, input, 1: single-cycle pulse that latches cfg_mask, cfg_bps and cfg_shift.
REQ-015 Port out_data, output, OW: head word of the FIFO.
REQ-016 Port out_valid, output, 1: FIFO is not empty.
REQ-017 Port out_ready, input, 1: consumer accepts; a pop occurs when out_valid and out_ready are both high.
REQ-018 Port cfg_err, output, 1: the latched configuration is illegal.
REQ-019 Port overflow_count, output, 16: count of words dropped, saturating.

Function
REQ-020 Slice SHALL be component bits [W-1-shift : W-B-shift], with plain truncation and no rounding.
REQ-021 The per-sample bit string SHALL be, for each enabled channel in ascending index order, I slice then Q slice, earliest bit at the MSB.
REQ-022 P SHALL equal 2*B*popcount(latched mask).
REQ-023 cfg_err SHALL be 1 when the mask is zero, when P > OW, or when shift+B > W.
REQ-024 While cfg_err is 1, in_valid SHALL be ignored; the FIFO SHALL still drain.
REQ-025 The accumulator SHALL be 2*OW bits with a fill counter of 0..2*OW-1.
REQ-026 Each accepted sample SHALL append P bits below the current fill.
REQ-027 When fill+P >= OW, the top OW bits SHALL be emitted as one word and the remainder left-aligned and retained, with fill becoming fill+P-OW.
REQ-028 At most one word SHALL be emitted per sample, which follows from P <= OW.
REQ-029 Pipeline: stage 1 registers the compacted P bits on the edge that samples in_valid (edge k).
REQ-030 Pipeline: stage 2 updates the accumulator and pushes any emitted word to the FIFO at edge k+1.
REQ-031 With the FIFO empty, out_valid SHALL rise after edge k+1, fall-through, with out_data valid in the same cycle.
REQ-032 in_valid may be high every cycle, giving full throughput with no bubbles.
REQ-033 When a push meets a full FIFO, the word SHALL be dropped and overflow_count incremented, saturating at 0xFFFF.
REQ-034 A push and a pop in the same cycle on a full FIFO SHALL succeed with no drop.
REQ-035 Simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-036 FIFO pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit.
REQ-037 cfg_load SHALL latch the new configuration, clear the accumulator fill to 0 and flush the stage 1 register.
REQ-038 cfg_load SHALL NOT alter FIFO contents or overflow_count.
REQ-039 An in_valid coincident with cfg_load SHALL be discarded.
REQ-040 A partial word in the accumulator at cfg_load SHALL be discarded, not emitted.
REQ-041 Each cfg_load SHALL re-evaluate cfg_err on the following cycle.

Reset
REQ-042 On assertion of source_reset_n, the FIFO SHALL empty, out_valid SHALL be 0, out_data SHALL be 0, fill SHALL be 0, stage 1 SHALL be invalid and overflow_count SHALL be 0.
REQ-043 On assertion of source_reset_n, the latched configuration SHALL become mask=1, bps=3, shift=0, giving cfg_err=0 and P=16 for default parameters.
REQ-044 Reset asserted mid-word SHALL lose all buffered data.
REQ-045 Reset deassertion SHALL be synchronised to source_clk by the instantiating logic.
REQ-046 The first in_valid SHALL be honoured on the second edge after release.

Verification
REQ-047 Post-reset defaults with ch0 I=0xA5, Q=0x3C and one in_valid -> out_data=0xA53C with out_valid high two cycles later; sustained samples give one word per cycle.
REQ-048 cfg mask=0011, bps=1, shift=0, with samples (I0=0xC0, Q0=0x40, I1=0x80, Q1=0x00) then all zeros -> single word 0xD800.
REQ-049 cfg mask=0001, bps=0, shift=1, with 16 samples of I=0x40, Q=0x00 -> word 0xAAAA.
REQ-050 out_ready=0 with 10 words generated -> 8 words held and overflow_count=2; releasing out_ready drains them in order.
REQ-051 cfg mask=1111 with bps=3 (P=64), or bps=2 with shift=5 -> cfg_err=1 and no words produced; a legal cfg_load clears cfg_err.
REQ-052 cfg_load after 3 samples at P=4, then 4 samples of 0xF0 -> partial word discarded and the next word comes only from post-load samples.
